// File: rtl/dffe_multi_reg.sv
`default_nettype none
// ============================================================================
//  Module   : dffe_multi_reg
//  Purpose  : WIDTH-bit enabled register with hold, load, shift, rotate,
//             wrapping/saturating count and synchronous clear modes.
//             Asynchronous clear, registered terminal-count pulse and a
//             combinational zero flag.
//  Revision : 1.0  initial release
// ============================================================================
module dffe_multi_reg #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 WRAP      = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  output logic [WIDTH-1:0]  q,
  output logic              sout,
  output logic              tc,
  output logic              zero
);

  // Operation encodings; all eight codes are meaningful.
  localparam logic [2:0] C_MODE_HOLD = 3'b000;
  localparam logic [2:0] C_MODE_LOAD = 3'b001;
  localparam logic [2:0] C_MODE_SHL  = 3'b010;
  localparam logic [2:0] C_MODE_SHR  = 3'b011;
  localparam logic [2:0] C_MODE_INC  = 3'b100;
  localparam logic [2:0] C_MODE_DEC  = 3'b101;
  localparam logic [2:0] C_MODE_ROL  = 3'b110;
  localparam logic [2:0] C_MODE_SCLR = 3'b111;

  localparam logic [WIDTH-1:0] C_ONES = '1;
  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_q;
  logic             tc_d;

  // Next-state selection; tc_d is a pulse request, so it defaults low and is
  // raised only on an enabled overflow/underflow attempt.
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (en) begin
      case (mode)
        C_MODE_HOLD: q_d = q_q;
        C_MODE_LOAD: q_d = d;
        C_MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin};
        C_MODE_SHR:  q_d = {sin, q_q[WIDTH-1:1]};
        C_MODE_INC: begin
          if (q_q == C_ONES) begin
            tc_d = 1'b1;
            // Saturating counters park at all-ones instead of wrapping.
            q_d  = (WRAP != 0) ? C_ZERO : C_ONES;
          end else begin
            q_d  = q_q + C_ONE;
          end
        end
        C_MODE_DEC: begin
          if (q_q == C_ZERO) begin
            tc_d = 1'b1;
            // Saturating counters park at zero instead of wrapping.
            q_d  = (WRAP != 0) ? C_ONES : C_ZERO;
          end else begin
            q_d  = q_q - C_ONE;
          end
        end
        C_MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        C_MODE_SCLR: q_d = RESET_VAL;
        default:     q_d = q_q;
      endcase
    end
  end

  // State register; clr acts immediately and masks every clock edge while high.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q  <= RESET_VAL;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  // Serial output follows the bit that the current shift/rotate will discard.
  always_comb begin
    sout = 1'b0;
    case (mode)
      C_MODE_SHL,
      C_MODE_ROL: sout = q_q[WIDTH-1];
      C_MODE_SHR: sout = q_q[0];
      default:    sout = 1'b0;
    endcase
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign zero = (q_q == C_ZERO);

endmodule
`default_nettype wire
